pipe_stage_reg: RTL and testbench

//  Parametrised pipeline register chain with valid/ready handshake, stall and flush; successor
//  to the fixed per-stage buffers (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries a data payload and a

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/pipe_stage_cell.sv | 45 ++++
 rtl/pipe_stage_reg.sv | 120 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, depth limit and control-payload layout for pipeline stage registers
// Contents:
//   DATA_W_DEF  default data payload width
//   STAGES_MAX  deepest legal register chain
//   pipe_ctrl_t control fields carried beside the data; all-zero encodes a NOP
//   CTRL_W_DEF  default control width, derived from pipe_ctrl_t
//   CTRL_NOP    the bubble encoding
package pipe_pkg;

  localparam int DATA_W_DEF = 96;
  localparam int STAGES_MAX = 4;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
  } pipe_ctrl_t;

  localparam int         CTRL_W_DEF = $bits(pipe_ctrl_t);
  localparam pipe_ctrl_t CTRL_NOP   = '0;

endpackage

// File: rtl/pipe_stage_cell.sv
// rtl/pipe_stage_cell.sv - one valid/ctrl/data register of the stage chain
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   flush               kill the entry held here (data is kept, valid/ctrl cleared)
//   adv                 this stage may load from upstream this cycle
//   up_valid/data/ctrl  entry offered by the upstream stage
//   valid_q/data_q/ctrl_q  registered entry
module pipe_stage_cell
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              adv,
  input  logic              up_valid,
  input  logic [DATA_W-1:0] up_data,
  input  logic [CTRL_W-1:0] up_ctrl,
  output logic              valid_q,
  output logic [DATA_W-1:0] data_q,
  output logic [CTRL_W-1:0] ctrl_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (adv) begin
      valid_q <= up_valid;
      // bubbles carry an all-zero control word so they act as NOPs downstream
      ctrl_q  <= up_valid ? up_ctrl : '0;
      // data is left alone on a bubble to avoid needless toggling of the wide payload
      if (up_valid) begin
        data_q <= up_data;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised pipeline register chain with valid/ready, stall and flush
// Optional feature: define SKID_EN to add a one-entry skid buffer in front of stage 0,
// which registers in_ready and removes the combinational path from out_ready.
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   flush                         drop every in-flight entry
//   in_valid/in_ready             upstream handshake
//   in_data/in_ctrl               upstream payload
//   out_valid/out_ready           downstream handshake (out_ready=0 stalls)
//   out_data/out_ctrl             head-stage payload; out_ctrl is zero whenever out_valid=0
// Parameters: DATA_W, CTRL_W, STAGES (1..STAGES_MAX, latency = STAGES cycles)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
);

  logic              valid_q [STAGES];
  logic [DATA_W-1:0] data_q  [STAGES];
  logic [CTRL_W-1:0] ctrl_q  [STAGES];
  // rdy[i]: stage i may load this cycle; an empty stage always may, which compresses bubbles
  logic [STAGES:0]   rdy;

  logic              s0_valid;
  logic [DATA_W-1:0] s0_data;
  logic [CTRL_W-1:0] s0_ctrl;

  assign rdy[STAGES] = out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    assign rdy[i] = !valid_q[i] | rdy[i+1];
    if (i == 0) begin : g_first
      pipe_stage_cell #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_cell (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .adv      (rdy[i]),
        .up_valid (s0_valid),
        .up_data  (s0_data),
        .up_ctrl  (s0_ctrl),
        .valid_q  (valid_q[i]),
        .data_q   (data_q[i]),
        .ctrl_q   (ctrl_q[i])
      );
    end else begin : g_next
      pipe_stage_cell #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_cell (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .adv      (rdy[i]),
        .up_valid (valid_q[i-1]),
        .up_data  (data_q[i-1]),
        .up_ctrl  (ctrl_q[i-1]),
        .valid_q  (valid_q[i]),
        .data_q   (data_q[i]),
        .ctrl_q   (ctrl_q[i])
      );
    end
  end

`ifdef SKID_EN
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              in_fire;

  // depends only on state, flush and rst: out_ready never reaches in_ready
  assign in_ready = !skid_valid & !flush & !rst;
  assign in_fire  = in_valid & in_ready;

  // a parked entry is older than anything arriving, so it goes first
  assign s0_valid = skid_valid | in_fire;
  assign s0_data  = skid_valid ? skid_data : in_data;
  assign s0_ctrl  = skid_valid ? skid_ctrl : in_ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
    end else if (flush) begin
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
    end else if (skid_valid) begin
      if (rdy[0]) begin
        skid_valid <= 1'b0;
        skid_ctrl  <= '0;
      end
    end else if (in_fire && !rdy[0]) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
      skid_ctrl  <= in_ctrl;
    end
  end
`else
  assign in_ready = rdy[0] & !flush & !rst;
  assign s0_valid = in_valid & in_ready;
  assign s0_data  = in_data;
  assign s0_ctrl  = in_ctrl;
`endif

  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_ctrl  = ctrl_q[STAGES-1];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg (STAGES=3 and STAGES=2 instances)
module tb_pipe_stage_reg;

  localparam int DW = 96;
  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic          in_ready3, out_valid3;
  logic [DW-1:0] out_data3;
  logic [CW-1:0] out_ctrl3;
  logic          in_ready2, out_valid2;
  logic [DW-1:0] out_data2;
  logic [CW-1:0] out_ctrl2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .STAGES(3)) u3 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3), .out_ctrl(out_ctrl3)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .STAGES(2)) u2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_ctrl(out_ctrl2)
  );

  function automatic logic [DW-1:0] mk_data(input logic [CW-1:0] c);
    return {c, 8'hD0, 32'hCAFE_0000, c, 8'h3C};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_ctrl = '0; in_data = '0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_ctrl = 24'h000055; in_data = mk_data(24'h000055);
    tick; tick;
    #1;
    checks++; if (in_ready3 !== 1'b0) begin errors++; $display("FAIL reset_in_ready3 got %0b want 0", in_ready3); end
    checks++; if (out_valid3 !== 1'b0) begin errors++; $display("FAIL reset_out_valid3 got %0b want 0", out_valid3); end
    checks++; if (out_ctrl3 !== '0) begin errors++; $display("FAIL reset_out_ctrl3 got %h want 0", out_ctrl3); end
    checks++; if (out_data3 !== '0) begin errors++; $display("FAIL reset_out_data3 got %h want 0", out_data3); end
    checks++; if (in_ready2 !== 1'b0) begin errors++; $display("FAIL reset_in_ready2 got %0b want 0", in_ready2); end
    checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL reset_out_valid2 got %0b want 0", out_valid2); end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_streaming;
    logic exp_v;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      in_valid = (c < 10);
      in_ctrl  = CW'(c + 1);
      in_data  = mk_data(CW'(c + 1));
      #1;
      if (c < 10) begin
        checks++; if (in_ready3 !== 1'b1) begin errors++; $display("FAIL stream_in_ready c=%0d got %0b want 1", c, in_ready3); end
      end
      exp_v = (c >= 3 && c <= 12);
      checks++; if (out_valid3 !== exp_v) begin errors++; $display("FAIL stream_out_valid c=%0d got %0b want %0b", c, out_valid3, exp_v); end
      if (exp_v) begin
        checks++;
        if (out_ctrl3 !== CW'(c - 2) || out_data3 !== mk_data(CW'(c - 2))) begin
          errors++; $display("FAIL stream_payload c=%0d got ctrl %h want %h", c, out_ctrl3, CW'(c - 2));
        end
      end else begin
        checks++; if (out_ctrl3 !== '0) begin errors++; $display("FAIL stream_bubble_ctrl c=%0d got %h want 0", c, out_ctrl3); end
      end
      tick;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stall;
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 24'h0000A1; in_data = mk_data(24'h0000A1);
    #1;
    checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL stall_accept_a got %0b want 1", in_ready2); end
    tick;
    in_ctrl = 24'h0000B2; in_data = mk_data(24'h0000B2);
    #1;
    checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL stall_accept_b got %0b want 1", in_ready2); end
    tick;
    in_ctrl = 24'h0000C3; in_data = mk_data(24'h0000C3);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (in_ready2 !== 1'b0) begin errors++; $display("FAIL stall_in_ready c=%0d got %0b want 0", c, in_ready2); end
      checks++;
      if (out_valid2 !== 1'b1 || out_ctrl2 !== 24'h0000A1 || out_data2 !== mk_data(24'h0000A1)) begin
        errors++; $display("FAIL stall_hold c=%0d got v=%0b ctrl=%h want v=1 ctrl=0000a1", c, out_valid2, out_ctrl2);
      end
      // the 3-deep instance still has one bubble on the first stall cycle, then fills up
      checks++; if (in_ready3 !== (c == 0)) begin errors++; $display("FAIL stall_compress3 c=%0d got %0b want %0b", c, in_ready3, (c == 0)); end
      tick;
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready2 !== 1'b1 || out_ctrl2 !== 24'h0000A1) begin errors++; $display("FAIL stall_release got rdy=%0b ctrl=%h want rdy=1 ctrl=0000a1", in_ready2, out_ctrl2); end
    tick;
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid2 !== 1'b1 || out_ctrl2 !== 24'h0000B2) begin errors++; $display("FAIL stall_order_b got v=%0b ctrl=%h want v=1 ctrl=0000b2", out_valid2, out_ctrl2); end
    tick;
    #1;
    checks++; if (out_valid2 !== 1'b1 || out_ctrl2 !== 24'h0000C3) begin errors++; $display("FAIL stall_order_c got v=%0b ctrl=%h want v=1 ctrl=0000c3", out_valid2, out_ctrl2); end
    tick;
    #1;
    checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL stall_drained got %0b want 0", out_valid2); end
  endtask

  task automatic test_bubble;
    do_reset();
    out_ready = 1'b1;
    in_ctrl = 24'h00003F;
    in_valid = 1'b1; in_data = mk_data(24'h000111); tick;
    in_valid = 1'b0; in_data = mk_data(24'h000222); tick;
    in_valid = 1'b1; in_data = mk_data(24'h000333);
    #1;
    checks++;
    if (out_valid2 !== 1'b1 || out_ctrl2 !== 24'h00003F || out_data2 !== mk_data(24'h000111)) begin
      errors++; $display("FAIL bubble_first got v=%0b ctrl=%h want v=1 ctrl=00003f", out_valid2, out_ctrl2);
    end
    tick;
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL bubble_valid got %0b want 0", out_valid2); end
    checks++; if (out_ctrl2 !== '0) begin errors++; $display("FAIL bubble_ctrl got %h want 0", out_ctrl2); end
    checks++; if (out_data2 !== mk_data(24'h000111)) begin errors++; $display("FAIL bubble_data_held got %h want %h", out_data2, mk_data(24'h000111)); end
    tick;
    #1;
    checks++;
    if (out_valid2 !== 1'b1 || out_ctrl2 !== 24'h00003F || out_data2 !== mk_data(24'h000333)) begin
      errors++; $display("FAIL bubble_third got v=%0b ctrl=%h want v=1 ctrl=00003f", out_valid2, out_ctrl2);
    end
    tick;
  endtask

  task automatic test_flush;
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 24'h0000A1; in_data = mk_data(24'h0000A1); tick;
    in_ctrl = 24'h0000B2; in_data = mk_data(24'h0000B2); tick;
    flush = 1'b1; in_ctrl = 24'h0000EE; in_data = mk_data(24'h0000EE);
    #1;
    checks++; if (in_ready2 !== 1'b0) begin errors++; $display("FAIL flush_in_ready2 got %0b want 0", in_ready2); end
    checks++; if (in_ready3 !== 1'b0) begin errors++; $display("FAIL flush_in_ready3 got %0b want 0", in_ready3); end
    tick;
    flush = 1'b0; out_ready = 1'b1;
    in_ctrl = 24'h000011; in_data = mk_data(24'h000011);
    #1;
    checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %0b want 0", out_valid2); end
    checks++; if (out_ctrl2 !== '0) begin errors++; $display("FAIL flush_out_ctrl got %h want 0", out_ctrl2); end
    checks++; if (out_data2 !== mk_data(24'h0000A1)) begin errors++; $display("FAIL flush_data_held got %h want %h", out_data2, mk_data(24'h0000A1)); end
    tick;
    in_ctrl = 24'h000022; in_data = mk_data(24'h000022);
    #1;
    checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL flush_refill_empty got %0b want 0", out_valid2); end
    tick;
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid2 !== 1'b1 || out_ctrl2 !== 24'h000011) begin errors++; $display("FAIL flush_first_out got v=%0b ctrl=%h want v=1 ctrl=000011", out_valid2, out_ctrl2); end
    tick;
    #1;
    checks++; if (out_valid2 !== 1'b1 || out_ctrl2 !== 24'h000022) begin errors++; $display("FAIL flush_second_out got v=%0b ctrl=%h want v=1 ctrl=000022", out_valid2, out_ctrl2); end
    tick;
  endtask

  task automatic test_skid;
    logic [CW-1:0] q[$];
    logic [CW-1:0] exp_c;
    int sent;
    int got;
    sent = 1; got = 0;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      out_ready = !((c >= 1 && c < 7) || (c >= 15 && c < 18));
      in_valid  = (sent <= 20);
      in_ctrl   = CW'(sent);
      in_data   = mk_data(CW'(sent));
      #1;
      if (out_valid2 && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL skid_spurious c=%0d got ctrl %h want none", c, out_ctrl2);
        end else begin
          exp_c = q.pop_front();
          if (out_ctrl2 !== exp_c || out_data2 !== mk_data(exp_c)) begin
            errors++; $display("FAIL skid_order c=%0d got ctrl %h want %h", c, out_ctrl2, exp_c);
          end
        end
        got++;
      end
      if (in_valid && in_ready2) begin
        q.push_back(CW'(sent));
        sent++;
      end
      tick;
    end
    checks++; if (got != 20) begin errors++; $display("FAIL skid_count got %0d want 20", got); end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_ctrl = '0; in_data = '0;
    test_reset();
`ifdef SKID_EN
    test_skid();
`else
    test_streaming();
    test_stall();
    test_bubble();
    test_flush();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
